// File: rtl/mem_issue_queue.sv
// In-order memory issue queue: buffers load/store micro-ops, wakes pending operands from the
// writeback bus, and issues the head entry combinationally once its operands (and ROB head, for stores) are ready.
module mem_issue_queue #(
    parameter int DEPTH = 8,
    parameter int PR_W  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    disp_valid,
    output logic                    disp_ready,
    input  logic [3:0]              disp_opcode,
    input  logic [4:0]              disp_rob,
    input  logic [15:0]             disp_base,
    input  logic [PR_W-1:0]         disp_off_tag,
    input  logic                    disp_off_rdy,
    input  logic [7:0]              disp_off_val,
    input  logic [PR_W-1:0]         disp_data_tag,
    input  logic                    disp_data_rdy,
    input  logic [7:0]              disp_data_val,
    input  logic [3:0]              disp_imm,
    input  logic [PR_W-1:0]         disp_dest_reg,
    input  logic [7:0]              disp_dest_arch,
    input  logic                    wb_valid,
    input  logic [PR_W-1:0]         wb_tag,
    input  logic [7:0]              wb_data,
    input  logic [4:0]              rob_head,
    output logic                    iss_valid,
    input  logic                    iss_ready,
    output logic [3:0]              iss_opcode,
    output logic [4:0]              iss_rob,
    output logic [15:0]             iss_base,
    output logic [7:0]              iss_offset,
    output logic [7:0]              iss_data,
    output logic [3:0]              iss_imm,
    output logic [PR_W-1:0]         iss_dest_reg,
    output logic [7:0]              iss_dest_arch,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [3:0]      opcode;
        logic [4:0]      rob;
        logic [15:0]     base;
        logic [PR_W-1:0] off_tag;
        logic            off_rdy;
        logic [7:0]      off_val;
        logic [PR_W-1:0] data_tag;
        logic            data_rdy;
        logic [7:0]      data_val;
        logic [3:0]      imm;
        logic [PR_W-1:0] dest_reg;
        logic [7:0]      dest_arch;
    } entry_t;

    entry_t             ent_q [DEPTH];
    logic [DEPTH-1:0]   vld_q;
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CNT_W-1:0]   count_q;

    entry_t             head_ent;
    entry_t             new_ent_d;
    logic               disp_fire;
    logic               iss_fire;

    assign disp_ready = (count_q < CNT_W'(DEPTH));
    assign count      = count_q;
    assign disp_fire  = disp_valid & disp_ready;
    assign head_ent   = ent_q[head_q];

    // Stores may only issue at the ROB head; loads only need their operands.
    assign iss_valid = vld_q[head_q] & head_ent.off_rdy & head_ent.data_rdy &
                       (~head_ent.opcode[0] | (rob_head == head_ent.rob)) & ~flush;
    assign iss_fire  = iss_valid & iss_ready;

    assign iss_opcode    = head_ent.opcode;
    assign iss_rob       = head_ent.rob;
    assign iss_base      = head_ent.base;
    assign iss_offset    = head_ent.off_val;
    assign iss_data      = head_ent.data_val;
    assign iss_imm       = head_ent.imm;
    assign iss_dest_reg  = head_ent.dest_reg;
    assign iss_dest_arch = head_ent.dest_arch;

    // Incoming entry, with a same-cycle writeback captured so it cannot be missed.
    always_comb begin
        new_ent_d.opcode    = disp_opcode;
        new_ent_d.rob       = disp_rob;
        new_ent_d.base      = disp_base;
        new_ent_d.off_tag   = disp_off_tag;
        new_ent_d.off_rdy   = disp_off_rdy;
        new_ent_d.off_val   = disp_off_val;
        new_ent_d.data_tag  = disp_data_tag;
        new_ent_d.data_rdy  = disp_data_rdy;
        new_ent_d.data_val  = disp_data_val;
        new_ent_d.imm       = disp_imm;
        new_ent_d.dest_reg  = disp_dest_reg;
        new_ent_d.dest_arch = disp_dest_arch;
        if (wb_valid && !disp_off_rdy && (disp_off_tag == wb_tag)) begin
            new_ent_d.off_rdy = 1'b1;
            new_ent_d.off_val = wb_data;
        end
        if (wb_valid && !disp_data_rdy && (disp_data_tag == wb_tag)) begin
            new_ent_d.data_rdy = 1'b1;
            new_ent_d.data_val = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (vld_q[i] && wb_valid) begin
                    if (!ent_q[i].off_rdy && (ent_q[i].off_tag == wb_tag)) begin
                        ent_q[i].off_rdy <= 1'b1;
                        ent_q[i].off_val <= wb_data;
                    end
                    if (!ent_q[i].data_rdy && (ent_q[i].data_tag == wb_tag)) begin
                        ent_q[i].data_rdy <= 1'b1;
                        ent_q[i].data_val <= wb_data;
                    end
                end
            end
            // Head and tail slots differ whenever both fire: dispatch is blocked when full.
            if (iss_fire) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + PTR_W'(1);
            end
            if (disp_fire) begin
                ent_q[tail_q] <= new_ent_d;
                vld_q[tail_q] <= 1'b1;
                tail_q        <= tail_q + PTR_W'(1);
            end
            if (disp_fire && !iss_fire) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!disp_fire && iss_fire) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/mem_issue_queue.md
Name: mem_issue_queue

Overview:
- In-order issue queue and scheduler for the memory pipeline; sits between dispatch/rename and the two-stage load/store pipeline.
- Buffers memory micro-ops and captures pending index/store-data operands from the writeback bus.
- Issues strictly in program order, one per cycle, when operands are ready; stores additionally wait until they reach the ROB head.
- Supports full flush on mispredict/exception.

Parameters:
- DEPTH, 8, number of queue entries (power of two, >=2)
- PR_W, 6, physical register tag width (matches PR_ADDR_W)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  queue can accept
- disp_opcode  in  4  opcode; bit0=1 store, 0 load
- disp_rob  in  5  ROB entry
- disp_base  in  16  base address
- disp_off_tag  in  PR_W  index register tag
- disp_off_rdy  in  1  index value already available
- disp_off_val  in  8  index value if ready
- disp_data_tag  in  PR_W  store data tag
- disp_data_rdy  in  1  store data available; loads drive 1
- disp_data_val  in  8  store data if ready
- disp_imm  in  4  imm field; bit3=zero-page wrap, passed through
- disp_dest_reg  in  PR_W  destination physical register
- disp_dest_arch  in  8  destination arch-reg mask
- wb_valid  in  1  writeback broadcast valid
- wb_tag  in  PR_W  writeback tag
- wb_data  in  8  writeback value
- rob_head  in  5  ROB entry currently at commit head
- iss_valid  out  1  issue to pipeline
- iss_ready  in  1  pipeline accepts
- iss_opcode  out  4  to pipeline opcode
- iss_rob  out  5  to pipeline ROB_entry
- iss_base  out  16  to pipeline base_val
- iss_offset  out  8  to pipeline offset
- iss_data  out  8  to pipeline data
- iss_imm  out  4  to pipeline imm
- iss_dest_reg  out  PR_W  to pipeline dest_reg
- iss_dest_arch  out  8  to pipeline dest_arch_regs
- count  out  clog2(DEPTH)+1  occupancy

Behaviour:
- Storage: circular buffer, head/tail pointers of clog2(DEPTH) bits wrapping DEPTH-1 -> 0; count tracks occupancy separately (distinguishes full/empty).
- Reset: head=tail=0, count=0, all entry valid bits 0.
  - iss_valid=0, disp_ready=1.
  - iss_* data outputs undefined (X allowed) while iss_valid=0.
- disp_ready = (count < DEPTH), purely from registered count; no same-cycle issue bypass when full.
- Dispatch fires on disp_valid & disp_ready: entry written at tail on clock edge; tail++, count++.
- Wakeup, per cycle, for every valid entry:
  - if wb_valid and operand not ready and tag == wb_tag, capture wb_data and set ready at the edge.
  - Both operands of one entry may match the same broadcast.
- Dispatch bypass: if a dispatched operand is not ready and wb_valid & wb_tag equals its tag in the same cycle, store wb_data and mark ready.
- Issue (combinational from head entry): iss_valid = head valid & off_rdy & data_rdy & (load | rob_head == entry rob) & ~flush.
  - iss_* reflect head entry fields; iss_offset = captured index value, iss_data = captured store data.
- Issue fires on iss_valid & iss_ready: head entry invalidated, head++, count--.
- Dispatch and issue in the same cycle: count unchanged, both pointers advance.
- Latency:
  - dispatch with all operands ready (load, or store at ROB head) -> iss_valid the next cycle;
  - wakeup at cycle t -> eligible at t+1.
- In-order rule: a ready younger entry never issues past an unready head (memory ordering).
- flush:
  - all valid bits cleared, head=tail=0, count=0 at the edge;
  - same-cycle dispatch is dropped;
  - iss_valid forced 0 during the flush cycle.
- rst dominates flush and dispatch.
- Tag 0 is not special; matching is purely by equality.

Test Plan:
- Reset, dispatch load (base 0x1200, off rdy 0x05, dest 3) -> next cycle iss_valid=1, iss_base=0x1200, iss_offset=0x05, iss_dest_reg=3; count 1 -> 0 after issue.
- Load with off_tag=7 unready; wb_valid tag 7 data 0x10 two cycles later -> iss_valid rises the cycle after wb, iss_offset=0x10.
- Store rob=4 with data ready, rob_head=2 -> iss_valid=0; set rob_head=4 -> iss_valid=1 same cycle, iss_opcode[0]=1.
- Fill 8 entries with iss_ready=0 -> disp_ready=0 at count=8; simultaneous disp_valid ignored.
  - Release iss_ready -> in-order drain, ROB ids match dispatch order, pointer wrap correct.
- Head unready (tag 9), entry 2 ready -> no issue until wb tag 9.
  - Dispatch with wb tag match in same cycle -> operand captured.
- Half-full queue, assert flush with simultaneous disp_valid -> next cycle count=0, iss_valid=0, dropped op never issues.
